// File: rtl/mips_pkg.sv
// Opcode encodings and fetch FSM states shared by the fetch sequencer and the control decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_LW, OP_SW: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select: jump/jal target, taken beq, else pc+4.
// Controls are masked by legal so X from the decoder on unknown opcodes cannot reach the PC.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr,
  input  logic        Jump,
  input  logic        Jal,
  input  logic        Branch,
  input  logic        alu_zero,
  input  logic        legal,
  output logic [31:0] next_pc,
  output logic [31:0] link_addr
);

  logic        jump_take;
  logic        branch_take;
  logic [31:0] br_off;

  assign link_addr   = pc + 32'd4;
  assign jump_take   = legal & (Jump | Jal);
  assign branch_take = legal & Branch & alu_zero;
  assign br_off      = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = link_addr;
    if (jump_take) begin
      next_pc = {link_addr[31:28], instr[25:0], 2'b00};
    end else if (branch_take) begin
      next_pc = link_addr + br_off;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, fetches one word per req/ack round trip and holds it for decode until consumed.
// No prefetch: a new request is raised only after the held instruction issues; a missing ack faults.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        Jump,
  input  logic        Jal,
  input  logic        Branch,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        illegal_op,
  output logic        fetch_err
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [7:0]  CNT_LAST         = 8'(TIMEOUT - 1);

  fetch_state_e state;
  logic [7:0]   cnt;
  logic         legal;
  logic [31:0]  next_pc;

  assign opcode    = instr[31:26];
  assign imem_addr = pc;
  assign legal     = is_legal_op(instr[31:26]);

  next_pc_calc u_next_pc (
    .pc        (pc),
    .instr     (instr[25:0]),
    .Jump      (Jump),
    .Jal       (Jal),
    .Branch    (Branch),
    .alu_zero  (alu_zero),
    .legal     (legal),
    .next_pc   (next_pc),
    .link_addr (link_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC_ALIGNED;
      instr       <= 32'd0;
      cnt         <= 8'd0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      illegal_op  <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      case (state)
        FETCH: begin
          // First cycle out of reset only raises the request; acks are not accepted yet.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            cnt         <= 8'd0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end else if (cnt == CNT_LAST) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            cnt       <= 8'd0;
            state     <= FAULT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            pc          <= {next_pc[31:2], 2'b00};
            illegal_op  <= ~legal;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end
        FAULT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, fetch latency, jump/branch/jal targets, wrap, illegal opcode, timeout.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic        Jump, Jal, Branch, alu_zero;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        illegal_op;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Jump(Jump), .Jal(Jal), .Branch(Branch), .alu_zero(alu_zero),
    .pc(pc), .link_addr(link_addr), .illegal_op(illegal_op), .fetch_err(fetch_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a request, answers it, and leaves the bench in the ISSUE cycle.
  task automatic fetch_word(input logic [31:0] word, output logic ok);
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
    ok = (imem_req === 1'b1);
    if (ok) begin
      imem_ack   = 1'b1;
      imem_rdata = word;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  task automatic handshake(input logic j, input logic jl, input logic br, input logic z);
    instr_ready = 1'b1;
    Jump = j; Jal = jl; Branch = br; alu_zero = z;
    tick();
    instr_ready = 1'b0;
    Jump = 1'b0; Jal = 1'b0; Branch = 1'b0; alu_zero = 1'b0;
  endtask

  task automatic run_instr(input string name, input logic [31:0] word,
                           input logic j, input logic jl, input logic br, input logic z,
                           input logic [31:0] exp_pc);
    logic ok;
    fetch_word(word, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_fetch_timeout: imem_req=%b required 1", name, imem_req);
    end
    handshake(j, jl, br, z);
    checks++;
    if (pc !== exp_pc) begin
      failures++;
      $display("FAIL %s_pc: got %h required %h", name, pc, exp_pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({imem_req, instr_valid, illegal_op, fetch_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: req/valid/ill/err=%b required 0000",
               {imem_req, instr_valid, illegal_op, fetch_err});
    end
    checks++;
    if (pc !== 32'h0 || instr !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs: pc=%h instr=%h required 0 0", pc, instr);
    end
  endtask

  task automatic test_first_fetch();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL first_req_c%0d: req=%b addr=%h valid=%b required 1 0 0",
                 c, imem_req, imem_addr, instr_valid);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'h0043_2820;
    tick();
    imem_ack   = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0043_2820 || opcode !== 6'd0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL first_issue: valid=%b instr=%h op=%h req=%b required 1 00432820 00 0",
               instr_valid, instr, opcode, imem_req);
    end
    handshake(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0 || illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL first_next: req=%b addr=%h valid=%b ill=%b required 1 00000004 0 0",
               imem_req, imem_addr, instr_valid, illegal_op);
    end
  endtask

  // beq -12 from pc=4 lands on 0xFFFF_FFFC, then hold with an ack glitch, then R-type wraps to 0.
  task automatic test_hold_and_wrap();
    logic ok;
    run_instr("beq_neg_wrap", {6'b000100, 5'd1, 5'd2, 16'hFFFD}, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    fetch_word(32'h0128_4020, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hold_fetch_timeout: imem_req=%b required 1", imem_req);
    end
    for (int c = 0; c < 5; c++) begin
      imem_ack   = (c == 2);
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack   = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h0128_4020 || pc !== 32'hFFFF_FFFC || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL hold_c%0d: valid=%b instr=%h pc=%h req=%b required 1 01284020 fffffffc 0",
                 c, instr_valid, instr, pc, imem_req);
      end
    end
    checks++;
    if (link_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_link: got %h required 00000000", link_addr);
    end
    handshake(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pc: pc=%h addr=%h required 0 0", pc, imem_addr);
    end
  endtask

  task automatic test_beq();
    run_instr("j_0x100", {6'b000010, 26'h40}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100);
    run_instr("beq_taken", {6'b000100, 5'd3, 5'd3, 16'hFFFE}, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00FC);
    run_instr("rtype_fc", 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100);
    run_instr("beq_not_taken", {6'b000100, 5'd3, 5'd4, 16'hFFFE}, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0104);
  endtask

  // Region hops via j: each target takes its top nibble from pc+4.
  task automatic test_jal();
    logic ok;
    run_instr("j_hop0", {6'b000010, 26'h3FF_FFFF}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0FFF_FFFC);
    run_instr("j_hop1", {6'b000010, 26'h3FF_FFFF}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1FFF_FFFC);
    run_instr("j_hop2", {6'b000010, 26'h3FF_FFFF}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2FFF_FFFC);
    run_instr("j_hop3", {6'b000010, 26'h000_0004}, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3000_0010);
    fetch_word({6'b000011, 26'h000_0040}, ok);
    checks++;
    if (!ok || link_addr !== 32'h3000_0014 || opcode !== 6'b000011) begin
      failures++;
      $display("FAIL jal_link: ok=%b link=%h op=%b required 1 30000014 000011", ok, link_addr, opcode);
    end
    handshake(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pc !== 32'h3000_0100 || illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL jal_target: pc=%h ill=%b required 30000100 0", pc, illegal_op);
    end
  endtask

  task automatic test_illegal();
    logic ok;
    fetch_word(32'hFC00_0123, ok);
    checks++;
    if (!ok || opcode !== 6'b111111) begin
      failures++;
      $display("FAIL illegal_fetch: ok=%b op=%b required 1 111111", ok, opcode);
    end
    handshake(1'bx, 1'bx, 1'bx, 1'bx);
    checks++;
    if (illegal_op !== 1'b1 || pc !== 32'h3000_0104 || (^imem_addr) === 1'bx) begin
      failures++;
      $display("FAIL illegal_pulse: ill=%b pc=%h addr=%h required 1 30000104 30000104",
               illegal_op, pc, imem_addr);
    end
    tick();
    checks++;
    if (illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL illegal_once: ill=%b required 0", illegal_op);
    end
  endtask

  // Entered one cycle into FETCH from test_illegal; that tick was the second request cycle.
  task automatic test_timeout();
    for (int c = 0; c < 14; c++) tick();
    checks++;
    if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_last_wait: req=%b err=%b required 1 0", imem_req, fetch_err);
    end
    tick();
    checks++;
    if (imem_req !== 1'b0 || fetch_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_fault: req=%b err=%b required 0 1", imem_req, fetch_err);
    end
    for (int c = 0; c < 6; c++) begin
      imem_ack   = c[0];
      imem_rdata = 32'h0000_0020;
      tick();
      imem_ack   = 1'b0;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1) begin
        failures++;
        $display("FAIL fault_hold_c%0d: req=%b valid=%b err=%b required 0 0 1",
                 c, imem_req, instr_valid, fetch_err);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h0 || fetch_err !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL fault_reset: pc=%h err=%b req=%b required 0 0 0", pc, fetch_err, imem_req);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL fault_restart: req=%b addr=%h required 1 0", imem_req, imem_addr);
    end
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    Jump = 1'b0; Jal = 1'b0; Branch = 1'b0; alu_zero = 1'b0;
    test_reset();
    test_first_fetch();
    test_hold_and_wrap();
    test_beq();
    test_jal();
    test_illegal();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
